// File: rtl/alignment_traceback.sv
// Needleman-Wunsch traceback walker: re-derives the alignment path from a stored score matrix,
// one neighbour read at a time, and streams the operations from the (N,M) corner back to (0,0).
module alignment_traceback #(
    parameter int N = 29,
    parameter int M = 29,
    parameter int W = 32,
    parameter int SW = 8,
    parameter logic signed [W-1:0] MATCH = 1,
    parameter logic signed [W-1:0] MISMATCH = 0,
    parameter logic signed [W-1:0] GAP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N*SW-1:0]   seq_a,
    input  logic [M*SW-1:0]   seq_b,
    output logic              rd_en,
    output logic [$clog2(N+1)-1:0] rd_i,
    output logic [$clog2(M+1)-1:0] rd_j,
    input  logic [W-1:0]      rd_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [1:0]        op_code,
    output logic              op_last,
    output logic [6:0]        path_len,
    output logic              finish,
    output logic              err
);

    localparam int IW = $clog2(N+1);
    localparam int JW = $clog2(M+1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_CUR  = 3'd1;
    localparam logic [2:0] RD_DIAG = 3'd2;
    localparam logic [2:0] RD_UP   = 3'd3;
    localparam logic [2:0] RD_LEFT = 3'd4;
    localparam logic [2:0] EMIT    = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    localparam logic [1:0] OP_MATCH    = 2'b00;
    localparam logic [1:0] OP_MISMATCH = 2'b01;
    localparam logic [1:0] OP_DEL      = 2'b10;
    localparam logic [1:0] OP_INS      = 2'b11;

    logic [2:0]      state_q, state_d;
    logic            phase_q, phase_d;
    logic [IW-1:0]   i_q, i_d, ni, tgt_i;
    logic [JW-1:0]   j_q, j_d, nj, tgt_j;
    logic [W-1:0]    hcur_q, hcur_d, hnb_q, hnb_d;
    logic [1:0]      op_q, op_d, arr_op;
    logic [6:0]      len_q, len_d;
    logic            err_q, err_d;
    logic [N*SW-1:0] a_q, a_d;
    logic [M*SW-1:0] b_q, b_d;
    logic [SW-1:0]   sym_a, sym_b;
    logic            sym_eq, last_move;
    logic [2:0]      arr_state;
    logic [W-1:0]    diag_sum, gap_sum;

    always_comb begin
        sym_a = '0;
        for (int k = 1; k <= N; k++) begin
            if (i_q == IW'(k)) sym_a = a_q[k*SW-1 -: SW];
        end
        sym_b = '0;
        for (int k = 1; k <= M; k++) begin
            if (j_q == JW'(k)) sym_b = b_q[k*SW-1 -: SW];
        end
    end

    assign sym_eq   = (sym_a == sym_b);
    assign diag_sum = rd_data + (sym_eq ? MATCH : MISMATCH);
    assign gap_sum  = rd_data + GAP;

    // Position reached once the pending op is accepted.
    always_comb begin
        ni = i_q;
        nj = j_q;
        unique case (op_q)
            OP_MATCH, OP_MISMATCH: begin
                ni = i_q - IW'(1);
                nj = j_q - JW'(1);
            end
            OP_DEL: ni = i_q - IW'(1);
            OP_INS: nj = j_q - JW'(1);
        endcase
    end

    assign last_move = (ni == '0) && (nj == '0);

    // What to do on arriving at a cell: finish, walk a matrix edge without reading, or test.
    always_comb begin
        tgt_i     = (state_q == EMIT) ? ni : i_q;
        tgt_j     = (state_q == EMIT) ? nj : j_q;
        arr_state = RD_DIAG;
        arr_op    = op_q;
        if (tgt_i == '0 && tgt_j == '0) begin
            arr_state = DONE;
        end else if (tgt_i == '0) begin
            arr_state = EMIT;
            arr_op    = OP_INS;
        end else if (tgt_j == '0) begin
            arr_state = EMIT;
            arr_op    = OP_DEL;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        i_d     = i_q;
        j_d     = j_q;
        hcur_d  = hcur_q;
        hnb_d   = hnb_q;
        op_d    = op_q;
        len_d   = len_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_en   = 1'b0;
        rd_i    = '0;
        rd_j    = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = seq_a;
                    b_d     = seq_b;
                    i_d     = IW'(N);
                    j_d     = JW'(M);
                    len_d   = '0;
                    err_d   = 1'b0;
                    phase_d = 1'b0;
                    state_d = RD_CUR;
                end
            end
            RD_CUR: begin
                if (!phase_q) begin
                    rd_en   = 1'b1;
                    rd_i    = i_q;
                    rd_j    = j_q;
                    phase_d = 1'b1;
                end else begin
                    hcur_d  = rd_data;
                    phase_d = 1'b0;
                    state_d = arr_state;
                    op_d    = arr_op;
                end
            end
            RD_DIAG: begin
                if (!phase_q) begin
                    rd_en   = 1'b1;
                    rd_i    = i_q - IW'(1);
                    rd_j    = j_q - JW'(1);
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (hcur_q == diag_sum) begin
                        op_d    = sym_eq ? OP_MATCH : OP_MISMATCH;
                        hnb_d   = rd_data;
                        state_d = EMIT;
                    end else begin
                        state_d = RD_UP;
                    end
                end
            end
            RD_UP: begin
                if (!phase_q) begin
                    rd_en   = 1'b1;
                    rd_i    = i_q - IW'(1);
                    rd_j    = j_q;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (hcur_q == gap_sum) begin
                        op_d    = OP_DEL;
                        hnb_d   = rd_data;
                        state_d = EMIT;
                    end else begin
                        state_d = RD_LEFT;
                    end
                end
            end
            RD_LEFT: begin
                if (!phase_q) begin
                    rd_en   = 1'b1;
                    rd_i    = i_q;
                    rd_j    = j_q - JW'(1);
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (hcur_q == gap_sum) begin
                        op_d    = OP_INS;
                        hnb_d   = rd_data;
                        state_d = EMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                if (op_ready) begin
                    i_d     = ni;
                    j_d     = nj;
                    len_d   = len_q + 7'd1;
                    hcur_d  = hnb_q;
                    phase_d = 1'b0;
                    state_d = arr_state;
                    op_d    = arr_op;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            hcur_q  <= '0;
            hnb_q   <= '0;
            op_q    <= OP_MATCH;
            len_q   <= '0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            i_q     <= i_d;
            j_q     <= j_d;
            hcur_q  <= hcur_d;
            hnb_q   <= hnb_d;
            op_q    <= op_d;
            len_q   <= len_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign op_valid = (state_q == EMIT);
    assign op_code  = op_q;
    assign op_last  = op_valid && last_move;
    assign path_len = len_q;
    assign finish   = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: doc/alignment_traceback.md
ALIGNMENT_TRACEBACK -- requirements
Module: alignment_traceback

Interface
REQ-001 SHALL have parameter N, default 29, length of sequence A (rows 1..N of the score matrix).
REQ-002 SHALL have parameter M, default 29, length of sequence B (columns 1..M).
REQ-003 SHALL have parameter W, default 32, score width in bits (two's complement).
REQ-004 SHALL have parameter SW, default 8, symbol width in bits.
REQ-005 SHALL have parameters MATCH, MISMATCH and GAP (signed, W bits), defaults 1, 0 and 0, which are the scores added for diagonal-equal, diagonal-unequal and gap moves.
REQ-006 SHALL define local widths IW=clog2(N+1) and JW=clog2(M+1).
REQ-007 SHALL have ports as follows; the clock and reset are fixed: one clock; reset is synchronous and active-high.
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a traceback; ignored unless IDLE or DONE.
- seq_a  input  N*SW  sequence A, symbol i (1-based) at bits [i*SW-1 -: SW]; captured on accepted start.
- seq_b  input  M*SW  sequence B, same packing; captured on accepted start.
- rd_en  output  1  score-matrix read request.
- rd_i  output  IW  read row index.
- rd_j  output  JW  read column index.
- rd_data  input  W  H(rd_i,rd_j), valid exactly one cycle after rd_en.
- op_valid  output  1  alignment operation available.
- op_ready  input  1  consumer accepts the operation.
- op_code  output  2  00 MATCH, 01 MISMATCH, 10 DELETE (i-1), 11 INSERT (j-1).
- op_last  output  1  qualifies the final operation (move reaches (0,0)).
- path_len  output  7  operations emitted in the current or last run.
- finish  output  1  level, high in DONE.
- err  output  1  level, high when no consistent predecessor was found.

Function
REQ-008 SHALL implement states IDLE, RD_CUR, RD_DIAG, RD_UP, RD_LEFT, EMIT, DONE; the CMP phase of each RD state is the cycle after its read issue.
REQ-009 On accepted start, the block SHALL set (i,j)=(N,M), clear path_len and err, and issue a read of H(N,M) in RD_CUR.
REQ-010 Each RD state SHALL assert rd_en for exactly one cycle and then compare on rd_data in the following cycle; at most one read is outstanding at a time.
REQ-011 The diagonal test SHALL be H(i,j) == H(i-1,j-1) + (a[i]==b[j] ? MATCH : MISMATCH), with the sum truncated to W bits; a pass selects op 00 or 01 and the move (i-1,j-1).
REQ-012 The up test SHALL be H(i,j) == H(i-1,j) + GAP; a pass selects op 10.
REQ-013 The left test SHALL be H(i,j) == H(i,j-1) + GAP; a pass selects op 11.
REQ-014 Tests SHALL run with priority diagonal, then up, then left; RD_UP is entered only when the diagonal test fails, and RD_LEFT only when the up test fails.
REQ-015 If all three tests fail, the block SHALL set err=1 and go to DONE without emitting.
REQ-016 When i==0 and j>0, the block SHALL emit op 11 with no read; when j==0 and i>0, it SHALL emit op 10 with no read.
REQ-017 In EMIT, op_valid SHALL be held with op_code and op_last stable until op_ready; the handshake completes on op_valid & op_ready.
REQ-018 On handshake, the block SHALL update (i,j), increment path_len, and take H(current) from the neighbour score already read; no re-read of the current cell.
REQ-019 After the handshake that reaches (0,0), the block SHALL go to DONE with op_last having been 1 on that op.
REQ-020 In DONE, finish SHALL be 1; a start SHALL restart the run with finish dropping in the next cycle.
REQ-021 A start in any other state SHALL be ignored.
REQ-022 Maximum path length is N+M operations; path_len SHALL never wrap for N+M <= 127.
REQ-023 Ops SHALL be emitted in reverse alignment order, from the (N,M) end toward the (0,0) start.

Reset
REQ-024 On reset, including mid-run, the block SHALL go to IDLE next cycle with rd_en, op_valid, op_last, finish and err at 0, path_len at 0, op_code 00 and rd_i/rd_j at 0.
REQ-025 A pending rd_data after reset SHALL be ignored.

Verification
REQ-026 Identity case: N=M=3, A=B="ACG", true NW matrix, op_ready=1 -> three op 00, op_last on the third, path_len=3, finish=1, err=0.
REQ-027 Backpressure: hold op_ready=0 for 5 cycles during EMIT -> op_valid=1 and op_code unchanged for all 5 cycles, one op counted.
REQ-028 Boundary walk: matrix whose path reaches (0,2) -> two op 11 emitted with rd_en=0 during those EMITs, last one with op_last=1.
REQ-029 Corrupt matrix: H(N,M)=99 inconsistent with all neighbours -> three reads (diag, up, left), then err=1, finish=1, op_valid never asserted.
REQ-030 Reset mid-run after two ops -> next cycle IDLE, all outputs 0; a fresh start reproduces the full sequence from (N,M).
REQ-031 Start pulse during RD_DIAG -> ignored; i, j and path_len are unaffected.
